// File: rtl/lsu_pkg.sv
// Shared types for the load/store unit store buffer: size codes, buffered
// store entry, control FSM states and byte-span helpers.
package lsu_pkg;

    localparam logic [2:0] WHB_B  = 3'd0;
    localparam logic [2:0] WHB_H  = 3'd1;
    localparam logic [2:0] WHB_W  = 3'd2;
    localparam logic [2:0] WHB_BU = 3'd3;
    localparam logic [2:0] WHB_HU = 3'd4;

    typedef struct packed {
        logic [31:0] addr;
        logic [2:0]  whb;
        logic [31:0] wdata;
    } sb_entry_t;

    typedef enum logic {
        IDLE    = 1'b0,
        LD_HOLD = 1'b1
    } lsu_state_t;

    function automatic logic [2:0] span_len(input logic [2:0] whb);
        case (whb)
            WHB_H, WHB_HU: span_len = 3'd2;
            WHB_W:         span_len = 3'd4;
            default:       span_len = 3'd1;
        endcase
    endfunction

    // Inclusive byte ranges compared in 33 bits so a span ending past 0xFFFFFFFF never wraps.
    function automatic logic spans_overlap(input logic [31:0] a0, input logic [2:0] w0,
                                           input logic [31:0] a1, input logic [2:0] w1);
        logic [32:0] lo0, hi0, lo1, hi1;
        lo0 = {1'b0, a0};
        hi0 = lo0 + {30'd0, span_len(w0)} - 33'd1;
        lo1 = {1'b0, a1};
        hi1 = lo1 + {30'd0, span_len(w1)} - 33'd1;
        return (lo0 <= hi1) && (lo1 <= hi0);
    endfunction

endpackage

// File: rtl/sbuf_fifo.sv
// Store-buffer FIFO: circular storage with per-slot valid bits so the
// top level can check every buffered store against an incoming load.
module sbuf_fifo
    import lsu_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        push,
    input  sb_entry_t                   push_entry,
    input  logic                        pop,
    output sb_entry_t                   head,
    output logic                        full,
    output logic                        empty,
    output sb_entry_t [DEPTH-1:0]       entries,
    output logic      [DEPTH-1:0]       entry_vld
);

    localparam int PW = $clog2(DEPTH);
    localparam logic [PW:0] FULL_CNT = (PW+1)'(DEPTH);

    logic [PW-1:0]         wr_ptr;
    logic [PW-1:0]         rd_ptr;
    logic [PW:0]           cnt;
    logic [DEPTH-1:0]      vld;
    sb_entry_t [DEPTH-1:0] mem;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= '0;
            vld    <= '0;
        end else begin
            if (push) begin
                wr_ptr      <= wr_ptr + PW'(1);
                vld[wr_ptr] <= 1'b1;
            end
            if (pop) begin
                rd_ptr      <= rd_ptr + PW'(1);
                vld[rd_ptr] <= 1'b0;
            end
            case ({push, pop})
                2'b10:   cnt <= cnt + (PW+1)'(1);
                2'b01:   cnt <= cnt - (PW+1)'(1);
                default: cnt <= cnt;
            endcase
        end
    end

    // Payload carries no reset; the valid bits alone say which slots mean anything.
    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= push_entry;
    end

    assign head      = mem[rd_ptr];
    assign full      = (cnt == FULL_CNT);
    assign empty     = (cnt == '0);
    assign entries   = mem;
    assign entry_vld = vld;

endmodule

// File: rtl/lsu_sbuf.sv
// Load/store unit front end: stores are posted into a small FIFO and drained
// to data memory when the port is free; loads wait out any overlapping store.
module lsu_sbuf
    import lsu_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [2:0]  req_whb,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        req_err,
    output logic        rsp_valid,
    output logic [31:0] rsp_data,
    input  logic        flush,
    output logic        sb_empty,
    output logic [31:0] mem_addr,
    output logic        mem_we,
    output logic [2:0]  mem_whb,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata
);

    lsu_state_t            state;
    logic [31:0]           ld_addr;
    logic [2:0]            ld_whb;
    sb_entry_t             head;
    sb_entry_t [DEPTH-1:0] entries;
    logic [DEPTH-1:0]      entry_vld;
    logic                  full;
    logic                  empty;
    logic                  illegal;
    logic                  overlap;
    logic                  store_acc;
    logic                  load_acc;
    logic                  drain;

    sbuf_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk        (clk),
        .rst_n      (rst_n),
        .push       (store_acc),
        .push_entry ('{addr: req_addr, whb: req_whb, wdata: req_wdata}),
        .pop        (drain),
        .head       (head),
        .full       (full),
        .empty      (empty),
        .entries    (entries),
        .entry_vld  (entry_vld)
    );

    always_comb begin
        overlap = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            if (entry_vld[i] && spans_overlap(entries[i].addr, entries[i].whb, req_addr, req_whb))
                overlap = 1'b1;
        end
    end

    assign illegal = (req_whb > WHB_HU) || (req_we && (req_whb > WHB_W));

    // Illegal requests are swallowed whenever flush allows; a full buffer hands the port to the drain.
    always_comb begin
        if (illegal)
            req_ready = !flush;
        else if (req_we)
            req_ready = !full && !flush;
        else
            req_ready = (state == IDLE) && !flush && !full && !overlap;
    end

    assign store_acc = req_valid && req_ready && req_we && !illegal;
    assign load_acc  = req_valid && req_ready && !req_we && !illegal;
    assign drain     = (state == IDLE) && !empty && !load_acc;

    always_comb begin
        mem_we    = 1'b0;
        mem_addr  = '0;
        mem_whb   = '0;
        mem_wdata = '0;
        if (load_acc) begin
            mem_addr = req_addr;
            mem_whb  = req_whb;
        end else if (state == LD_HOLD) begin
            mem_addr = ld_addr;
            mem_whb  = ld_whb;
        end else if (drain) begin
            mem_we    = 1'b1;
            mem_addr  = head.addr;
            mem_whb   = head.whb;
            mem_wdata = head.wdata;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            rsp_valid <= 1'b0;
            req_err   <= 1'b0;
        end else begin
            req_err   <= req_valid && req_ready && illegal;
            rsp_valid <= load_acc;
            case (state)
                IDLE:    if (load_acc) state <= LD_HOLD;
                LD_HOLD: state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (load_acc) begin
            ld_addr <= req_addr;
            ld_whb  <= req_whb;
        end
    end

    assign rsp_data = rsp_valid ? mem_rdata : '0;
    assign sb_empty = empty;

endmodule

// File: tb/tb_lsu_sbuf.sv
// Bench for lsu_sbuf: directed vector table, hand-written full/reset sequences,
// and randomized traffic against a program-order memory model.
module tb_lsu_sbuf;

    localparam int DEPTH = 4;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        req_valid = 1'b0, req_we = 1'b0, flush = 1'b0;
    logic [2:0]  req_whb = '0;
    logic [31:0] req_addr = '0, req_wdata = '0, mem_rdata = '0;
    logic        req_ready, req_err, rsp_valid, sb_empty, mem_we;
    logic [31:0] rsp_data, mem_addr, mem_wdata;
    logic [2:0]  mem_whb;

    lsu_sbuf #(.DEPTH(DEPTH)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
        .req_whb(req_whb), .req_addr(req_addr), .req_wdata(req_wdata),
        .req_err(req_err), .rsp_valid(rsp_valid), .rsp_data(rsp_data),
        .flush(flush), .sb_empty(sb_empty),
        .mem_addr(mem_addr), .mem_we(mem_we), .mem_whb(mem_whb),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
    );

    always #5 clk = ~clk;

    int n_chk = 0;
    int n_pass = 0;

    typedef struct {
        logic [31:0] addr;
        logic [2:0]  whb;
        logic [31:0] wdata;
    } wr_t;

    logic [7:0] dmem [1024] = '{default: 8'h00};
    logic [7:0] amem [1024];
    wr_t        wlog[$];

    wr_t         q[$];
    bit          m_hold, m_err;
    logic [31:0] m_haddr, m_val;
    logic [2:0]  m_hwhb;

    typedef struct {
        logic        v, we;
        logic [2:0]  whb;
        logic [31:0] a, d;
        logic        fl;
        logic        rdy, mwe;
        logic [31:0] maddr, mwdata;
        logic        rv;
        logic [31:0] rdata;
        logic        err, empty;
    } vec_t;
    vec_t tbl[$];

    function automatic int len_of(input logic [2:0] whb);
        if (whb == 3'd1 || whb == 3'd4) return 2;
        if (whb == 3'd2) return 4;
        return 1;
    endfunction

    function automatic logic [31:0] extend(input logic [31:0] raw, input logic [2:0] whb);
        case (whb)
            3'd0:    return {{24{raw[7]}}, raw[7:0]};
            3'd1:    return {{16{raw[15]}}, raw[15:0]};
            3'd3:    return {24'd0, raw[7:0]};
            3'd4:    return {16'd0, raw[15:0]};
            default: return raw;
        endcase
    endfunction

    function automatic logic [31:0] mem_load(input bit arch, input logic [31:0] a, input logic [2:0] whb);
        logic [31:0] raw;
        for (int i = 0; i < 4; i++)
            raw[8*i +: 8] = arch ? amem[10'(a + 32'(i))] : dmem[10'(a + 32'(i))];
        return extend(raw, whb);
    endfunction

    function automatic bit overlaps_pending(input logic [31:0] a, input logic [2:0] whb);
        for (int k = 0; k < q.size(); k++)
            for (int i = 0; i < len_of(q[k].whb); i++)
                for (int j = 0; j < len_of(whb); j++)
                    if (q[k].addr + 32'(i) == a + 32'(j)) return 1'b1;
        return 1'b0;
    endfunction

    // Behavioural data memory driven by the DUT's write port.
    always @(posedge clk) begin
        if (rst_n && mem_we) begin
            for (int i = 0; i < len_of(mem_whb); i++)
                dmem[10'(mem_addr + 32'(i))] = mem_wdata[8*i +: 8];
            wlog.push_back('{mem_addr, mem_whb, mem_wdata});
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    endtask

    task automatic step(input logic v, input logic we, input logic [2:0] whb,
                        input logic [31:0] a, input logic [31:0] d, input logic fl);
        @(negedge clk);
        req_valid = v; req_we = we; req_whb = whb; req_addr = a; req_wdata = d; flush = fl;
        #1 mem_rdata = mem_load(1'b0, mem_addr, mem_whb);
        #1;
    endtask

    task automatic idle();
        step(1'b0, 1'b0, 3'd0, 32'h0, 32'h0, 1'b0);
    endtask

    task automatic add_vec(input int v, input int we, input int whb, input logic [31:0] a,
                           input logic [31:0] d, input int fl, input int rdy, input int mwe,
                           input logic [31:0] maddr, input logic [31:0] mwdata, input int rv,
                           input logic [31:0] rdata, input int err, input int empty);
        vec_t r;
        r.v = 1'(v); r.we = 1'(we); r.whb = 3'(whb); r.a = a; r.d = d; r.fl = 1'(fl);
        r.rdy = 1'(rdy); r.mwe = 1'(mwe); r.maddr = maddr; r.mwdata = mwdata;
        r.rv = 1'(rv); r.rdata = rdata; r.err = 1'(err); r.empty = 1'(empty);
        tbl.push_back(r);
    endtask

    task automatic rand_cycle(input logic v, input logic we, input logic [2:0] whb,
                              input logic [31:0] a, input logic [31:0] d, input logic fl);
        bit          ill, full, e_rdy, acc, ld, st, e_drn;
        logic [31:0] e_ma, e_wd;
        logic [2:0]  e_mw;
        ill  = (whb >= 3'd5) || (we && whb > 3'd2);
        full = (q.size() == DEPTH);
        if (ill)     e_rdy = !fl;
        else if (we) e_rdy = !full && !fl;
        else         e_rdy = !m_hold && !fl && !full && !overlaps_pending(a, whb);
        acc   = v && e_rdy;
        ld    = acc && !we && !ill;
        st    = acc && we && !ill;
        e_drn = !m_hold && q.size() > 0 && !ld;
        e_ma = '0; e_mw = '0; e_wd = '0;
        if (ld) begin
            e_ma = a; e_mw = whb;
        end else if (m_hold) begin
            e_ma = m_haddr; e_mw = m_hwhb;
        end else if (e_drn) begin
            e_ma = q[0].addr; e_mw = q[0].whb; e_wd = q[0].wdata;
        end
        step(v, we, whb, a, d, fl);
        if (v) check("rnd req_ready", 32'(req_ready), 32'(e_rdy));
        check("rnd mem_we", 32'(mem_we), 32'(e_drn));
        check("rnd mem_addr", mem_addr, e_ma);
        check("rnd mem_whb", 32'(mem_whb), 32'(e_mw));
        check("rnd mem_wdata", mem_wdata, e_wd);
        check("rnd rsp_valid", 32'(rsp_valid), 32'(m_hold));
        check("rnd rsp_data", rsp_data, m_hold ? m_val : 32'h0);
        check("rnd req_err", 32'(req_err), 32'(m_err));
        check("rnd sb_empty", 32'(sb_empty), 32'(q.size() == 0));
        if (e_drn) void'(q.pop_front());
        if (st) begin
            q.push_back('{a, whb, d});
            for (int i = 0; i < len_of(whb); i++) amem[10'(a + 32'(i))] = d[8*i +: 8];
        end
        if (ld) begin
            m_val = mem_load(1'b1, a, whb); m_haddr = a; m_hwhb = whb;
        end
        m_hold = ld;
        m_err  = acc && ill;
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "timeout");
    end

    initial begin
        logic [2:0]  whb;
        logic [31:0] a0;
        int          bad;

        // Reset state
        @(negedge clk); @(negedge clk);
        check("reset sb_empty", 32'(sb_empty), 32'd1);
        check("reset mem_we", 32'(mem_we), 32'd0);
        check("reset rsp_valid", 32'(rsp_valid), 32'd0);
        check("reset req_err", 32'(req_err), 32'd0);
        check("reset mem_addr", mem_addr, 32'h0);
        rst_n = 1'b1;

        // v we whb addr data fl | rdy mwe maddr mwdata rv rdata err empty
        add_vec(1,1,2,32'h100,32'hDEADBEEF,0, 1,0,32'h0,  32'h0,       0,32'h0,       0,1);
        add_vec(1,0,2,32'h100,32'h0,       0, 0,1,32'h100,32'hDEADBEEF,0,32'h0,       0,0);
        add_vec(1,0,2,32'h100,32'h0,       0, 1,0,32'h100,32'h0,       0,32'h0,       0,1);
        add_vec(0,0,0,32'h0,  32'h0,       0, 0,0,32'h100,32'h0,       1,32'hDEADBEEF,0,1);
        add_vec(1,1,2,32'h100,32'hDEADBEEF,0, 1,0,32'h0,  32'h0,       0,32'h0,       0,1);
        add_vec(0,0,0,32'h0,  32'h0,       0, 1,1,32'h100,32'hDEADBEEF,0,32'h0,       0,0);
        add_vec(0,0,0,32'h0,  32'h0,       0, 1,0,32'h0,  32'h0,       0,32'h0,       0,1);
        add_vec(1,1,0,32'h203,32'h80,      0, 1,0,32'h0,  32'h0,       0,32'h0,       0,1);
        add_vec(1,0,1,32'h203,32'h0,       0, 0,1,32'h203,32'h80,      0,32'h0,       0,0);
        add_vec(1,0,1,32'h203,32'h0,       0, 1,0,32'h203,32'h0,       0,32'h0,       0,1);
        add_vec(0,0,0,32'h0,  32'h0,       0, 0,0,32'h203,32'h0,       1,32'h80,      0,1);
        add_vec(0,0,0,32'h0,  32'h0,       0, 1,0,32'h0,  32'h0,       0,32'h0,       0,1);
        add_vec(1,0,0,32'h203,32'h0,       0, 1,0,32'h203,32'h0,       0,32'h0,       0,1);
        add_vec(0,0,0,32'h0,  32'h0,       0, 0,0,32'h203,32'h0,       1,32'hFFFFFF80,0,1);
        add_vec(1,1,3,32'h300,32'h55,      0, 1,0,32'h0,  32'h0,       0,32'h0,       0,1);
        add_vec(0,0,0,32'h0,  32'h0,       0, 1,0,32'h0,  32'h0,       0,32'h0,       1,1);
        add_vec(1,0,5,32'h300,32'h0,       0, 1,0,32'h0,  32'h0,       0,32'h0,       0,1);
        add_vec(0,0,0,32'h0,  32'h0,       0, 1,0,32'h0,  32'h0,       0,32'h0,       1,1);
        add_vec(0,0,0,32'h0,  32'h0,       0, 1,0,32'h0,  32'h0,       0,32'h0,       0,1);
        add_vec(1,1,2,32'h40, 32'h11,      1, 0,0,32'h0,  32'h0,       0,32'h0,       0,1);
        add_vec(0,0,0,32'h0,  32'h0,       0, 1,0,32'h0,  32'h0,       0,32'h0,       0,1);

        wlog.delete();
        foreach (tbl[i]) begin
            step(tbl[i].v, tbl[i].we, tbl[i].whb, tbl[i].a, tbl[i].d, tbl[i].fl);
            check($sformatf("vec%0d req_ready", i), 32'(req_ready), 32'(tbl[i].rdy));
            check($sformatf("vec%0d mem_we", i), 32'(mem_we), 32'(tbl[i].mwe));
            check($sformatf("vec%0d mem_addr", i), mem_addr, tbl[i].maddr);
            check($sformatf("vec%0d mem_wdata", i), mem_wdata, tbl[i].mwdata);
            check($sformatf("vec%0d rsp_valid", i), 32'(rsp_valid), 32'(tbl[i].rv));
            check($sformatf("vec%0d rsp_data", i), rsp_data, tbl[i].rdata);
            check($sformatf("vec%0d req_err", i), 32'(req_err), 32'(tbl[i].err));
            check($sformatf("vec%0d sb_empty", i), 32'(sb_empty), 32'(tbl[i].empty));
        end
        check("vec write count", 32'(wlog.size()), 32'd3);

        // Fill to DEPTH by parking stores behind loads, then a fifth store
        wlog.delete();
        for (int k = 0; k < 4; k++) begin
            step(1'b1, 1'b1, 3'd2, 32'h400 + 32'(4*k), 32'hA0000000 + 32'(k), 1'b0);
            check($sformatf("fill store%0d ready", k), 32'(req_ready), 32'd1);
            if (k < 3) begin
                step(1'b1, 1'b0, 3'd2, 32'h500, 32'h0, 1'b0);
                check($sformatf("fill load%0d ready", k), 32'(req_ready), 32'd1);
            end
        end
        step(1'b1, 1'b1, 3'd2, 32'h410, 32'hA0000004, 1'b0);
        check("full store ready", 32'(req_ready), 32'd0);
        check("full drain mem_we", 32'(mem_we), 32'd1);
        check("full drain addr", mem_addr, 32'h400);
        step(1'b1, 1'b1, 3'd2, 32'h410, 32'hA0000004, 1'b0);
        check("fifth store ready", 32'(req_ready), 32'd1);
        for (int t = 0; t < 20 && !sb_empty; t++) idle();
        check("fill drained", 32'(sb_empty), 32'd1);
        check("fill write count", 32'(wlog.size()), 32'd5);
        for (int k = 0; k < 5; k++) begin
            if (k < wlog.size()) begin
                check($sformatf("fill write%0d addr", k), wlog[k].addr, 32'h400 + 32'(4*k));
                check($sformatf("fill write%0d data", k), wlog[k].wdata, 32'hA0000000 + 32'(k));
            end
        end

        // Reset with three stores buffered and a load response in flight
        for (int k = 0; k < 3; k++) begin
            step(1'b1, 1'b1, 3'd2, 32'h600 + 32'(4*k), 32'hB0000000 + 32'(k), 1'b0);
            step(1'b1, 1'b0, 3'd2, 32'h700, 32'h0, 1'b0);
        end
        idle();
        check("pre-reset rsp_valid", 32'(rsp_valid), 32'd1);
        check("pre-reset sb_empty", 32'(sb_empty), 32'd0);
        #1 rst_n = 1'b0;
        #1;
        check("mid-reset sb_empty", 32'(sb_empty), 32'd1);
        check("mid-reset rsp_valid", 32'(rsp_valid), 32'd0);
        check("mid-reset mem_we", 32'(mem_we), 32'd0);
        wlog.delete();
        @(negedge clk);
        rst_n = 1'b1;
        for (int t = 0; t < 8; t++) idle();
        check("post-reset writes", 32'(wlog.size()), 32'd0);
        check("post-reset sb_empty", 32'(sb_empty), 32'd1);

        // Randomized traffic against the program-order model
        for (int i = 0; i < 1024; i++) amem[i] = dmem[i];
        q.delete(); m_hold = 1'b0; m_err = 1'b0; m_val = '0; m_haddr = '0; m_hwhb = '0;
        for (int c = 0; c < 3000; c++) begin
            logic v, we, fl;
            v  = ($urandom_range(0, 3) != 0);
            we = 1'($urandom_range(0, 1));
            if ($urandom_range(0, 19) == 0) whb = 3'($urandom_range(3, 7));
            else if (we)                    whb = 3'($urandom_range(0, 2));
            else                            whb = 3'($urandom_range(0, 4));
            a0 = 32'h100 + 32'($urandom_range(0, 15));
            fl = ($urandom_range(0, 15) == 0);
            rand_cycle(v, we, whb, a0, $urandom, fl);
        end
        for (int t = 0; t < 2*DEPTH + 4; t++) rand_cycle(1'b0, 1'b0, 3'd0, 32'h0, 32'h0, 1'b0);
        bad = 0;
        for (int i = 0; i < 1024; i++) if (dmem[i] !== amem[i]) bad++;
        check("final memory image bytes differing", 32'(bad), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
